// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad. One column strobe is driven low at
//   a time, the row lines are synchronised and sampled once per column dwell
//   (scan tick), presses and releases are debounced, and every accepted key
//   is reported as a hex nibble {row_idx, col_idx}. The last four keys are
//   kept as a 16-bit value in display-data format, newest nibble in [3:0].
//
// Ports
//   CLK        in   1   system clock, all logic on posedge
//   clr_n      in   1   asynchronous active-low reset
//   row_in     in   4   keypad rows, active-low, asynchronous to CLK
//   key_clr    in   1   synchronous clear of key_data, active-high
//   col_ctrl   out  4   column strobe, exactly one bit low
//   key_valid  out  1   one-CLK pulse per accepted key
//   key_code   out  4   code of the last accepted key
//   key_data   out  16  last four keys, newest in [3:0]
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        CLK,
  input  logic        clr_n,
  input  logic [3:0]  row_in,
  input  logic        key_clr,
  output logic [3:0]  col_ctrl,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] key_data
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_sync1_q, row_sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic [15:0]   data_q, data_d;

  logic          tick;
  logic          accept;
  logic          singleLow;
  logic [3:0]    rowLow;
  logic [1:0]    rowIdx, colIdx;
  logic [3:0]    colRot;
  logic [CW-1:0] cntInc;

  // Scan tick: one CLK at the end of every column dwell.
  assign tick   = (div_q == DIV_MAX);
  assign div_d  = tick ? '0 : div_q + DW'(1);

  // A press is only meaningful when exactly one row line is low; two or more
  // low rows are a chord or ghost and are treated like no press at all.
  assign rowLow    = ~row_sync2_q;
  assign singleLow = (rowLow != 4'd0) && ((rowLow & (rowLow - 4'd1)) == 4'd0);

  assign colRot = {col_q[0], col_q[3:1]};
  assign cntInc = cnt_q + CW'(1);

  always_comb begin
    rowIdx = 2'd0;
    case (row_sync2_q)
      4'b1110: rowIdx = 2'd0;
      4'b1101: rowIdx = 2'd1;
      4'b1011: rowIdx = 2'd2;
      4'b0111: rowIdx = 2'd3;
      default: rowIdx = 2'd0;
    endcase
  end

  always_comb begin
    colIdx = 2'd0;
    case (col_q)
      4'b1110: colIdx = 2'd0;
      4'b1101: colIdx = 2'd1;
      4'b1011: colIdx = 2'd2;
      4'b0111: colIdx = 2'd3;
      default: colIdx = 2'd0;
    endcase
  end

  // Next-state logic. Every decision waits for a tick; between ticks the
  // column, candidate and counters simply hold.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (singleLow) begin
            cand_d = row_sync2_q;
            if (DEBOUNCE_CNT == 1) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d   = CW'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = colRot;
          end
        end
        DEBOUNCE: begin
          if (row_sync2_q == cand_q) begin
            if (cntInc == CNT_MAX) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            cnt_d   = '0;
            col_d   = colRot;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Column stays frozen on the held key; no auto-repeat.
          if (row_sync2_q == 4'b1111) begin
            if (cntInc == CNT_MAX) begin
              cnt_d   = '0;
              col_d   = colRot;
              state_d = SCAN;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      endcase
    end
  end

  // Output side: the accepted code lands on the edge that takes the decision,
  // so key_valid appears one CLK after the accepting tick. key_clr beats a
  // simultaneous accept for key_data only.
  always_comb begin
    valid_d = accept;
    code_d  = accept ? {rowIdx, colIdx} : code_q;
    data_d  = data_q;
    if (key_clr) begin
      data_d = 16'h0000;
    end else if (accept) begin
      data_d = {data_q[11:0], rowIdx, colIdx};
    end
  end

  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= SCAN;
      row_sync1_q <= 4'b1111;
      row_sync2_q <= 4'b1111;
      div_q       <= '0;
      col_q       <= 4'b1110;
      cand_q      <= 4'b1111;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      code_q      <= 4'h0;
      data_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      row_sync1_q <= row_in;
      row_sync2_q <= row_sync1_q;
      div_q       <= div_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      data_q      <= data_d;
    end
  end

  assign col_ctrl  = col_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_data  = data_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3, 10 ns clock.
//   A physical keypad model drives row_in from col_ctrl and the key being
//   pressed; a transaction-level model tracks the expected last-four-keys
//   value. Directed scenarios cover reset, rotation, bounce, chord, key_clr
//   and reset while a key is held; a random phase presses random keys.
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        clr_n;
  logic [3:0]  row_in;
  logic        key_clr;
  logic [3:0]  col_ctrl;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] key_data;

  int checks = 0;
  int failures = 0;
  int validCount = 0;
  logic [3:0]  codeAtValid = 4'h0;
  logic [15:0] dataAtValid = 16'h0;

  logic        pressed = 1'b0;
  logic [1:0]  prow = 2'd0;
  logic [1:0]  pcol = 2'd0;
  logic        rawMode = 1'b0;
  logic [3:0]  rawRow = 4'hF;
  logic [15:0] modelData = 16'h0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .CLK       (CLK),
    .clr_n     (clr_n),
    .row_in    (row_in),
    .key_clr   (key_clr),
    .col_ctrl  (col_ctrl),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_data  (key_data)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: the pressed key pulls its row low only while its column
  // is strobed. rawMode lets the bench force arbitrary row patterns.
  assign row_in = rawMode ? rawRow :
                  ((pressed && (col_ctrl[pcol] == 1'b0)) ? ~(4'b0001 << prow) : 4'hF);

  // Counts every CLK in which key_valid is high and records what came with it.
  always @(negedge CLK) begin
    if (key_valid) begin
      validCount  = validCount + 1;
      codeAtValid = key_code;
      dataAtValid = key_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      checkOutput("colOneLow", 32'($countones(~col_ctrl)), 32'd1);
    end
  endtask

  // Lands on the negedge right after col_ctrl rotates into 1110.
  task automatic waitColFresh();
    int n1 = 0;
    int n2 = 0;
    while (col_ctrl == 4'b1110 && n1 < 40) begin
      waitCycles(1);
      n1++;
    end
    while (col_ctrl != 4'b1110 && n2 < 40) begin
      waitCycles(1);
      n2++;
    end
    checkOutput("colFresh", 32'((n1 < 40) && (n2 < 40)), 32'd1);
  endtask

  task automatic clearPulse();
    key_clr = 1'b1;
    waitCycles(1);
    key_clr = 1'b0;
    modelData = 16'h0;
    checkOutput("keyClr", key_data, modelData);
  endtask

  task automatic applyStimulus(input logic [3:0] code, input int hold);
    int base;
    logic [3:0] expCol;
    base    = validCount;
    prow    = code[3:2];
    pcol    = code[1:0];
    expCol  = ~(4'b0001 << code[1:0]);
    pressed = 1'b1;
    waitCycles(hold);
    checkOutput("heldCol", col_ctrl, expCol);
    pressed = 1'b0;
    waitCycles(40);
    modelData = {modelData[11:0], code};
    checkOutput("validCount", validCount - base, 32'd1);
    checkOutput("codeAtValid", codeAtValid, code);
    checkOutput("keyCode", key_code, code);
    checkOutput("keyData", key_data, modelData);
  endtask

  initial begin
    int base;
    int n;
    logic [3:0] expCol;
    logic [3:0] rcode;
    clr_n   = 1'b0;
    key_clr = 1'b0;
    waitCycles(3);
    clr_n = 1'b1;

    // 1: reset values and free rotation.
    $display("[TB] reset and rotation");
    checkOutput("rstCol", col_ctrl, 4'b1110);
    checkOutput("rstValid", key_valid, 1'b0);
    checkOutput("rstCode", key_code, 4'h0);
    checkOutput("rstData", key_data, 16'h0);
    for (int k = 1; k <= 16; k++) begin
      int idx;
      waitCycles(1);
      idx    = (4 - ((k / 4) % 4)) % 4;
      expCol = ~(4'b0001 << idx);
      checkOutput("rotate", col_ctrl, expCol);
    end

    // 2: row 2 / col 1 held for 40 CLK, then released.
    $display("[TB] single key 9");
    base = validCount;
    prow = 2'd2;
    pcol = 2'd1;
    pressed = 1'b1;
    waitCycles(40);
    checkOutput("key9HeldCol", col_ctrl, 4'b1101);
    pressed = 1'b0;
    n = 0;
    while (col_ctrl == 4'b1101 && n < 40) begin
      waitCycles(1);
      n++;
    end
    checkOutput("key9NextCol", col_ctrl, 4'b1110);
    waitCycles(30);
    modelData = 16'h0009;
    checkOutput("key9Valid", validCount - base, 32'd1);
    checkOutput("key9Code", key_code, 4'h9);
    checkOutput("key9Data", key_data, 16'h0009);

    // 3: keys 1..5 fill and then shift the history.
    $display("[TB] key sequence");
    clearPulse();
    base = validCount;
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(4'(c), 50);
      if (c == 4) checkOutput("seq1234", key_data, 16'h1234);
    end
    checkOutput("seq2345", key_data, 16'h2345);
    checkOutput("seqPulses", validCount - base, 32'd5);

    // 4: a single low sample is rejected and the scan moves on.
    $display("[TB] bounce");
    base = validCount;
    waitColFresh();
    rawRow  = 4'b1011;
    rawMode = 1'b1;
    waitCycles(4);
    rawRow = 4'hF;
    waitCycles(4);
    checkOutput("bounceCol", col_ctrl, 4'b0111);
    waitCycles(30);
    rawMode = 1'b0;
    checkOutput("bounceValid", validCount - base, 32'd0);

    // 5: two rows low is never accepted.
    $display("[TB] chord");
    base = validCount;
    waitColFresh();
    rawRow  = 4'b1100;
    rawMode = 1'b1;
    waitCycles(4);
    checkOutput("chordCol", col_ctrl, 4'b0111);
    waitCycles(32);
    rawMode = 1'b0;
    rawRow  = 4'hF;
    checkOutput("chordValid", validCount - base, 32'd0);
    checkOutput("chordData", key_data, modelData);

    // Random keys with occasional clears.
    $display("[TB] random keys");
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) clearPulse();
      rcode = 4'($urandom_range(0, 15));
      applyStimulus(rcode, $urandom_range(45, 70));
    end

    // 6a: key_clr held across the accept: clear wins for key_data only.
    $display("[TB] clear during accept");
    base = validCount;
    key_clr = 1'b1;
    prow = 2'd3;
    pcol = 2'd2;
    pressed = 1'b1;
    n = 0;
    while (validCount == base && n < 60) begin
      waitCycles(1);
      n++;
    end
    checkOutput("clrAccValid", validCount - base, 32'd1);
    checkOutput("clrAccCode", codeAtValid, 4'hE);
    checkOutput("clrAccData", dataAtValid, 16'h0);
    waitCycles(20);
    pressed = 1'b0;
    key_clr = 1'b0;
    waitCycles(40);
    modelData = 16'h0;
    checkOutput("clrAccAfter", key_data, modelData);
    checkOutput("clrAccCount", validCount - base, 32'd1);

    // 6b: reset while a key is held returns everything to reset values.
    $display("[TB] reset while held");
    base = validCount;
    prow = 2'd1;
    pcol = 2'd2;
    pressed = 1'b1;
    n = 0;
    while (validCount == base && n < 60) begin
      waitCycles(1);
      n++;
    end
    checkOutput("heldValid", validCount - base, 32'd1);
    waitCycles(6);
    checkOutput("heldColPre", col_ctrl, 4'b1011);
    clr_n   = 1'b0;
    pressed = 1'b0;
    #1;
    checkOutput("midRstCol", col_ctrl, 4'b1110);
    checkOutput("midRstValid", key_valid, 1'b0);
    checkOutput("midRstCode", key_code, 4'h0);
    checkOutput("midRstData", key_data, 16'h0);
    waitCycles(3);
    clr_n = 1'b1;
    base = validCount;
    waitCycles(40);
    checkOutput("postRstValid", validCount - base, 32'd0);
    checkOutput("postRstData", key_data, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
